regfile_port_arbiter: RTL and testbench

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

---
 rtl/regfile_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Two-port register file access arbiter.
// Two requesters (0 = core, 1 = debug/IO) share one register file through a
// round-robin arbiter and a three-state sequencer (IDLE -> ACCESS -> DONE).
// A captured request is executed in ACCESS (gnt pulse, optional write strobe,
// read data sampled) and completed in DONE (ack pulse with rdata/err).
// Ports:
//   CLK, Reset            clock, asynchronous active-high reset
//   reqN/weN/addrN/wdataN request from requester N
//   gntN, ackN            one-cycle grant / completion pulses
//   rdata, err            shared read result and out-of-range flag
//   busy                  sequencer not idle
//   rf_sel, rf_rdata      register file read mux select / data
//   rf_we/rf_waddr/rf_wdata register file write port
module regfile_port_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 10,
  parameter int unsigned SEL_W  = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [SEL_W-1:0]  addr0,
  input  logic [SEL_W-1:0]  addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [SEL_W-1:0]  rf_sel,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [SEL_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q;
  logic                last1_q;      // 1: requester 1 was served last
  logic                gnt0_q, gnt1_q, ack0_q, ack1_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                busy_q;
  logic [SEL_W-1:0]    rf_sel_q, rf_waddr_q;
  logic                rf_we_q;
  logic [DATA_W-1:0]   rf_wdata_q;

  logic                win1_d;
  logic                cap_we_d;
  logic [SEL_W-1:0]    cap_addr_d;
  logic [DATA_W-1:0]   cap_wdata_d;

  function automatic logic in_range(input logic [SEL_W-1:0] a);
    return 32'(a) < 32'(NREGS);
  endfunction

  // Round-robin winner and its request fields, used only at the capture edge
  always_comb begin
    win1_d      = req1;
    if (req0 && req1) win1_d = ~last1_q;
    cap_we_d    = win1_d ? we1    : we0;
    cap_addr_d  = win1_d ? addr1  : addr0;
    cap_wdata_d = win1_d ? wdata1 : wdata0;
  end

  // Sequencer with all outputs registered
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      last1_q    <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rf_sel_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q    <= ACCESS;
            busy_q     <= 1'b1;
            last1_q    <= win1_d;
            gnt0_q     <= ~win1_d;
            gnt1_q     <= win1_d;
            rf_sel_q   <= cap_addr_d;
            rf_waddr_q <= cap_addr_d;
            rf_wdata_q <= cap_wdata_d;
            rf_we_q    <= cap_we_d && in_range(cap_addr_d);
          end
        end
        ACCESS: begin
          state_q <= DONE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          rf_we_q <= 1'b0;
          ack0_q  <= gnt0_q;
          ack1_q  <= gnt1_q;
          // rf_rdata still shows the pre-write contents at this edge
          if (in_range(rf_sel_q)) begin
            rdata_q <= rf_rdata;
            err_q   <= 1'b0;
          end else begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign rf_sel   = rf_sel_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Testbench for regfile_port_arbiter: register file environment, spec-level
// reference model (shadow registers + round-robin pointer), scenario tasks.
module tb_regfile_port_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 10;
  localparam int unsigned SEL_W  = 4;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              req0, req1, we0, we1;
  logic [SEL_W-1:0]  addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, ack0, ack1, err, busy, rf_we;
  logic [DATA_W-1:0] rdata, rf_rdata, rf_wdata;
  logic [SEL_W-1:0]  rf_sel, rf_waddr;

  int n_cmp  = 0;
  int n_fail = 0;

  // Register file environment (16 physical slots, only 0..NREGS-1 meaningful)
  logic [DATA_W-1:0] rf_mem [16];
  logic              ld_en;
  logic [SEL_W-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;

  // Reference model state
  logic [DATA_W-1:0] shadow [NREGS];
  int                m_last;

  regfile_port_arbiter #(.DATA_W(DATA_W), .NREGS(NREGS), .SEL_W(SEL_W)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .err(err), .busy(busy),
    .rf_sel(rf_sel), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 CLK = ~CLK;

  assign rf_rdata = rf_mem[rf_sel];

  always @(posedge CLK) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    else if (ld_en) rf_mem[ld_addr] <= ld_data;
  end

  // Mutual exclusion of grants and acks, every cycle out of reset
  always @(negedge CLK) begin
    if (!Reset) begin
      n_cmp++;
      if ((gnt0 && gnt1) || (ack0 && ack1)) begin
        n_fail++;
        $display("FAIL excl: gnt=%b%b ack=%b%b, required never both high", gnt0, gnt1, ack0, ack1);
      end
    end
  end

  function automatic int exp_winner(input bit r0, input bit r1);
    if (r0 && r1) return (m_last == 1) ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  // Waits for a grant (bounded), then the ack cycle; collects observations.
  task automatic observe(input bit drop, output int gid, output int lat,
                         output logic [SEL_W-1:0] sel, output int we_cnt,
                         output logic [SEL_W-1:0] waddr, output logic [DATA_W-1:0] wdata,
                         output int aid, output logic [DATA_W-1:0] rd,
                         output logic e, output bit to);
    gid = -1; lat = 0; sel = '0; we_cnt = 0; waddr = '0; wdata = '0;
    aid = -1; rd = '0; e = 1'b0; to = 1'b0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!(gnt0 || gnt1) && lat < 12);
    if (!(gnt0 || gnt1)) begin
      to = 1'b1;
      return;
    end
    gid = gnt1 ? 1 : 0;
    sel = rf_sel; waddr = rf_waddr; wdata = rf_wdata;
    we_cnt = int'(rf_we);
    if (drop) begin req0 = 1'b0; req1 = 1'b0; end
    @(negedge CLK);
    aid = ack0 ? 0 : (ack1 ? 1 : -1);
    rd = rdata; e = err;
    we_cnt += int'(rf_we);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    Reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    m_last = 1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_cmp++;
    if ({gnt0, gnt1, ack0, ack1, rf_we, err, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000000", {gnt0, gnt1, ack0, ack1, rf_we, err, busy});
    end
    n_cmp++;
    if (rdata !== 16'h0 || rf_sel !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_rd_sel: rdata=%h rf_sel=%h, required 0/0", rdata, rf_sel);
    end
    n_cmp++;
    if (rf_waddr !== 4'h0 || rf_wdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_wport: waddr=%h wdata=%h, required 0/0", rf_waddr, rf_wdata);
    end
    Reset = 1'b0;
    m_last = 1;
  endtask

  task automatic test_single_read();
    int gid, lat, we_cnt, aid; logic [SEL_W-1:0] sel, wa; logic [DATA_W-1:0] wd, rd; logic e; bit to;
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    observe(1'b1, gid, lat, sel, we_cnt, wa, wd, aid, rd, e, to);
    n_cmp++;
    if (to || gid !== 0 || lat !== 1) begin
      n_fail++;
      $display("FAIL read_gnt: to=%0d gid=%0d lat=%0d, required 0/0/1", to, gid, lat);
    end
    n_cmp++;
    if (sel !== 4'd3) begin n_fail++; $display("FAIL read_sel: got %0d, required 3", sel); end
    n_cmp++;
    if (aid !== 0 || rd !== 16'h1234 || e !== 1'b0 || we_cnt !== 0) begin
      n_fail++;
      $display("FAIL read_ack: aid=%0d rdata=%h err=%b we=%0d, required 0/1234/0/0", aid, rd, e, we_cnt);
    end
    m_last = 0;
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b0 || ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL read_idle: busy=%b ack0=%b, required 0/0", busy, ack0);
    end
  endtask

  task automatic test_write_read();
    int gid, lat, we_cnt, aid; logic [SEL_W-1:0] sel, wa; logic [DATA_W-1:0] wd, rd; logic e; bit to;
    logic [DATA_W-1:0] old;
    old = shadow[9];
    @(negedge CLK);
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd9; wdata1 = 16'hBEEF;
    observe(1'b1, gid, lat, sel, we_cnt, wa, wd, aid, rd, e, to);
    n_cmp++;
    if (to || gid !== 1 || we_cnt !== 1 || wa !== 4'd9 || wd !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL write_strobe: to=%0d gid=%0d we=%0d waddr=%0d wdata=%h, required 0/1/1/9/beef",
               to, gid, we_cnt, wa, wd);
    end
    n_cmp++;
    if (aid !== 1 || rd !== old || e !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ack: aid=%0d rdata=%h err=%b, required 1/%h/0", aid, rd, e, old);
    end
    shadow[9] = 16'hBEEF; m_last = 1;
    @(negedge CLK);
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd9;
    observe(1'b1, gid, lat, sel, we_cnt, wa, wd, aid, rd, e, to);
    n_cmp++;
    if (to || aid !== 1 || rd !== 16'hBEEF || we_cnt !== 0) begin
      n_fail++;
      $display("FAIL write_readback: aid=%0d rdata=%h we=%0d, required 1/beef/0", aid, rd, we_cnt);
    end
  endtask

  task automatic test_out_of_range();
    int gid, lat, we_cnt, aid; logic [SEL_W-1:0] sel, wa; logic [DATA_W-1:0] wd, rd; logic e; bit to;
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd12; wdata0 = 16'h7777;
    observe(1'b1, gid, lat, sel, we_cnt, wa, wd, aid, rd, e, to);
    n_cmp++;
    if (to || gid !== 0 || we_cnt !== 0) begin
      n_fail++;
      $display("FAIL oor_we: to=%0d gid=%0d we=%0d, required 0/0/0", to, gid, we_cnt);
    end
    n_cmp++;
    if (aid !== 0 || e !== 1'b1 || rd !== 16'h0) begin
      n_fail++;
      $display("FAIL oor_ack: aid=%0d err=%b rdata=%h, required 0/1/0000", aid, e, rd);
    end
    m_last = 0;
  endtask

  task automatic test_input_change();
    int lat, we_cnt;
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!gnt0 && lat < 12);
    n_cmp++;
    if (!gnt0 || rf_sel !== 4'd2) begin
      n_fail++;
      $display("FAIL chg_gnt: gnt0=%b rf_sel=%0d, required 1/2", gnt0, rf_sel);
    end
    we_cnt = int'(rf_we);
    addr0 = 4'd5; we0 = 1'b1; wdata0 = 16'h5555; req0 = 1'b0;
    @(negedge CLK);
    we_cnt += int'(rf_we);
    n_cmp++;
    if (ack0 !== 1'b1 || rdata !== shadow[2] || we_cnt !== 0) begin
      n_fail++;
      $display("FAIL chg_ack: ack0=%b rdata=%h we=%0d, required 1/%h/0", ack0, rdata, we_cnt, shadow[2]);
    end
    m_last = 0;
  endtask

  task automatic test_tie();
    int gid, lat, we_cnt, aid; logic [SEL_W-1:0] sel, wa; logic [DATA_W-1:0] wd, rd; logic e; bit to;
    logic [SEL_W-1:0] a0, a1;
    int exp_g;
    apply_reset();
    a0 = SEL_W'($urandom_range(NREGS - 1, 0));
    a1 = SEL_W'($urandom_range(NREGS - 1, 0));
    req0 = 1'b1; we0 = 1'b0; addr0 = a0;
    req1 = 1'b1; we1 = 1'b0; addr1 = a1;
    for (int k = 0; k < 4; k++) begin
      exp_g = exp_winner(1'b1, 1'b1);
      observe(1'b0, gid, lat, sel, we_cnt, wa, wd, aid, rd, e, to);
      n_cmp++;
      if (to || gid !== (k % 2) || gid !== exp_g || lat !== ((k == 0) ? 1 : 2)) begin
        n_fail++;
        $display("FAIL tie_%0d: to=%0d gid=%0d lat=%0d, required 0/%0d/%0d", k, to, gid, lat,
                 k % 2, (k == 0) ? 1 : 2);
      end
      n_cmp++;
      if (aid !== exp_g || rd !== shadow[(exp_g == 1) ? a1 : a0]) begin
        n_fail++;
        $display("FAIL tie_ack_%0d: aid=%0d rdata=%h, required %0d/%h", k, aid, rd, exp_g,
                 shadow[(exp_g == 1) ? a1 : a0]);
      end
      m_last = exp_g;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int gid, lat, we_cnt, aid; logic [SEL_W-1:0] sel, wa; logic [DATA_W-1:0] wd, rd; logic e; bit to;
    @(negedge CLK);
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd4; wdata0 = ~shadow[4];
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!gnt0 && lat < 12);
    n_cmp++;
    if (!gnt0 || rf_we !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_access: gnt0=%b rf_we=%b, required 1/1", gnt0, rf_we);
    end
    Reset = 1'b1; req0 = 1'b0;
    #1;
    n_cmp++;
    if ({gnt0, rf_we, busy, ack0} !== 4'b0 || rf_sel !== 4'h0 || rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_clear: gnt0=%b rf_we=%b busy=%b ack0=%b sel=%h rdata=%h, required all 0",
               gnt0, rf_we, busy, ack0, rf_sel, rdata);
    end
    @(negedge CLK);
    n_cmp++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_noack: ack=%b%b rf_we=%b, required 00/0", ack0, ack1, rf_we);
    end
    Reset = 1'b0; m_last = 1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd1;
    observe(1'b1, gid, lat, sel, we_cnt, wa, wd, aid, rd, e, to);
    n_cmp++;
    if (to || gid !== 0 || lat !== 1 || aid !== 0 || rd !== shadow[4]) begin
      n_fail++;
      $display("FAIL mid_after: to=%0d gid=%0d lat=%0d aid=%0d rdata=%h, required 0/0/1/0/%h",
               to, gid, lat, aid, rd, shadow[4]);
    end
    m_last = 0;
  endtask

  task automatic test_random();
    int gid, lat, we_cnt, aid; logic [SEL_W-1:0] sel, wa; logic [DATA_W-1:0] wd, rd; logic e; bit to;
    int r, w, exp_we;
    logic [SEL_W-1:0] ea; logic [DATA_W-1:0] ed, exp_rd; logic ewe;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      r = int'($urandom_range(3, 1));
      req0 = r[0]; req1 = r[1];
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = SEL_W'($urandom_range(15, 0)); addr1 = SEL_W'($urandom_range(15, 0));
      wdata0 = DATA_W'($urandom); wdata1 = DATA_W'($urandom);
      w = exp_winner(r[0], r[1]);
      ea  = (w == 1) ? addr1 : addr0;
      ed  = (w == 1) ? wdata1 : wdata0;
      ewe = (w == 1) ? we1 : we0;
      exp_rd = (32'(ea) < NREGS) ? shadow[ea] : 16'h0;
      exp_we = (ewe && 32'(ea) < NREGS) ? 1 : 0;
      observe(1'b1, gid, lat, sel, we_cnt, wa, wd, aid, rd, e, to);
      n_cmp++;
      if (to || gid !== w || lat !== 1 || sel !== ea || aid !== w) begin
        n_fail++;
        $display("FAIL rand_%0d_arb: to=%0d gid=%0d lat=%0d sel=%0d aid=%0d, required 0/%0d/1/%0d/%0d",
                 i, to, gid, lat, sel, aid, w, ea, w);
      end
      n_cmp++;
      if (we_cnt !== exp_we || (exp_we == 1 && (wa !== ea || wd !== ed))) begin
        n_fail++;
        $display("FAIL rand_%0d_wr: we=%0d waddr=%0d wdata=%h, required %0d/%0d/%h",
                 i, we_cnt, wa, wd, exp_we, ea, ed);
      end
      n_cmp++;
      if (rd !== exp_rd || e !== (32'(ea) >= NREGS)) begin
        n_fail++;
        $display("FAIL rand_%0d_rd: rdata=%h err=%b, required %h/%b", i, rd, e, exp_rd, 32'(ea) >= NREGS);
      end
      if (exp_we == 1) shadow[ea] = ed;
      m_last = w;
    end
  endtask

  initial begin
    Reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    m_last = 1;
    for (int i = 0; i < int'(NREGS); i++) shadow[i] = DATA_W'($urandom);
    shadow[3] = 16'h1234;
    shadow[9] = 16'h0009;
    // Preload register file with the DUT held in reset
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      ld_en = 1'b1; ld_addr = SEL_W'(i);
      ld_data = (i < int'(NREGS)) ? shadow[i] : (16'hA5A0 + DATA_W'(i));
    end
    @(negedge CLK);
    ld_en = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_out_of_range();
    test_input_change();
    test_tie();
    test_reset_mid();
    test_random();
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
